// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
//
// Front end for the vending FSM's coin input. The two raw coin-sensor levels
// are synchronised, debounced and validated. Each accepted coin is queued and
// then presented as a single-cycle coin code followed by idle cycles.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive mismatching synchronised cycles needed before
//                     a debounced level changes (2..15)
//   FIFO_DEPTH      : number of accepted coins that can wait (power of 2, 2..8)
//   GAP_CYCLES      : idle cycles forced on coin after every emitted coin (1..3)
//
// Ports
//   clk      : system clock
//   rst      : synchronous active-high reset
//   raw_5    : asynchronous, bouncy level from the 5-coin sensor
//   raw_10   : asynchronous, bouncy level from the 10-coin sensor
//   coin     : registered coin code (00 idle, 01 five, 10 ten; 11 never driven)
//   reject   : one-cycle pulse when a coin event is discarded as invalid
//   overflow : one-cycle pulse when a valid coin is dropped on a full queue
//   pending  : number of coins currently queued
// -----------------------------------------------------------------------------
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_5,
  input  logic       raw_10,
  output logic [1:0] coin,
  output logic       reject,
  output logic       overflow,
  output logic [3:0] pending
);

  localparam int         PW       = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES - 1);
  localparam logic [3:0] DEPTH    = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EMIT = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  // Coin code for a queued entry: entry bit 1 means a ten, 0 means a five.
  function automatic logic [1:0] coin_code(input logic is_ten);
    return is_ten ? 2'b10 : 2'b01;
  endfunction

  // Channel vectors use bit 0 for the five sensor and bit 1 for the ten sensor.
  logic [1:0]            sync1_r;
  logic [1:0]            sync2_r;
  logic [3:0]            cnt_r [2];
  logic [1:0]            deb_r;
  logic [1:0]            deb_d_r;

  logic [1:0]            rise_s;
  logic                  reject_s;
  logic                  valid_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  accept_s;
  logic                  overflow_s;

  logic [FIFO_DEPTH-1:0] mem_r;
  logic [PW-1:0]         wptr_r;
  logic [PW-1:0]         rptr_r;
  logic [3:0]            count_r;

  state_t                state_r;
  state_t                state_s;
  logic [1:0]            gap_r;
  logic                  emit_ten_r;
  logic [1:0]            coin_r;
  logic                  reject_r;
  logic                  overflow_r;

  // Two-flop synchroniser for both raw sensor levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= {raw_10, raw_5};
      sync2_r <= sync1_r;
    end
  end

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive mismatches;
  // deb_d_r keeps last cycle's level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r[0] <= 4'd0;
      cnt_r[1] <= 4'd0;
      deb_r    <= 2'b00;
      deb_d_r  <= 2'b00;
    end else begin
      deb_d_r <= deb_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i] <= 4'd0;
        end else if (cnt_r[i] == DB_LAST) begin
          deb_r[i] <= ~deb_r[i];
          cnt_r[i] <= 4'd0;
        end else begin
          cnt_r[i] <= cnt_r[i] + 4'd1;
        end
      end
    end
  end

  // Coin events are debounced rising edges; an event is invalid when both
  // channels rise together or the other channel is already high.
  always_comb begin
    rise_s   = deb_r & ~deb_d_r;
    reject_s = 1'b0;
    valid_s  = 1'b0;
    if (rise_s == 2'b11) begin
      reject_s = 1'b1;
    end else if ((rise_s[0] && deb_r[1]) || (rise_s[1] && deb_r[0])) begin
      reject_s = 1'b1;
    end else if (rise_s != 2'b00) begin
      valid_s = 1'b1;
    end else begin
      valid_s = 1'b0;
    end
  end

  // Output FSM next state; the IDLE->EMIT transition is also the FIFO pop.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != 4'd0) begin
          pop_s   = 1'b1;
          state_s = ST_EMIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        state_s = ST_GAP;
      end
      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_GAP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // The queue counts as full only if no entry leaves on the same edge, so a
  // push and pop together on a full queue is accepted.
  always_comb begin
    full_s     = (count_r == DEPTH) && !pop_s;
    accept_s   = valid_s && !full_s;
    overflow_s = valid_s && full_s;
  end

  // Coin queue: one bit per entry, pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r   <= '0;
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= 4'd0;
    end else begin
      if (accept_s) begin
        mem_r[wptr_r] <= rise_s[1];
        wptr_r        <= wptr_r + PW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PW'(1);
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + 4'd1;
        2'b01:   count_r <= count_r - 4'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state, gap timer, popped entry and the registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      gap_r      <= 2'd0;
      emit_ten_r <= 1'b0;
      coin_r     <= 2'b00;
      reject_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (pop_s) begin
        emit_ten_r <= mem_r[rptr_r];
      end
      if (state_r == ST_EMIT) begin
        gap_r <= 2'd0;
      end else if (state_r == ST_GAP) begin
        gap_r <= gap_r + 2'd1;
      end
      coin_r     <= (state_r == ST_EMIT) ? coin_code(emit_ten_r) : 2'b00;
      reject_r   <= reject_s;
      overflow_r <= overflow_s;
    end
  end

  assign coin     = coin_r;
  assign reject   = reject_r;
  assign overflow = overflow_r;
  assign pending  = count_r;

endmodule

// File: tb/tb_coin_acceptor.sv
module tb_coin_acceptor;

  localparam int SN = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic a5 = 1'b0, a10 = 1'b0, b5 = 1'b0, b10 = 1'b0;
  logic [1:0] coin_a, coin_b;
  logic rej_a, rej_b, ovf_a, ovf_b;
  logic [3:0] pend_a, pend_b;

  // dut 0: default parameters; dut 1: fast debounce, long gap, shallow queue
  coin_acceptor dut_a (
    .clk(clk), .rst(rst), .raw_5(a5), .raw_10(a10),
    .coin(coin_a), .reject(rej_a), .overflow(ovf_a), .pending(pend_a)
  );

  coin_acceptor #(.DEBOUNCE_CYCLES(2), .FIFO_DEPTH(2), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .raw_5(b5), .raw_10(b10),
    .coin(coin_b), .reject(rej_b), .overflow(ovf_b), .pending(pend_b)
  );

  logic [7:0] got_v [2];
  assign got_v[0] = {coin_a, rej_a, ovf_a, pend_a};
  assign got_v[1] = {coin_b, rej_b, ovf_b, pend_b};

  int errors = 0;
  int checks = 0;

  int P_D   [2] = '{4, 2};
  int P_G   [2] = '{1, 3};
  int P_DEP [2] = '{4, 2};

  // reference model state
  bit         samp    [2][2][SN];
  int         edge_n  [2] = '{0, 0};
  int         rst_edge[2] = '{0, 0};
  bit         deb     [2][2];
  bit         deb_old [2][2];
  int         mis     [2][2];
  bit         fq      [2][$];
  int         cool    [2];
  bit         emit_nx [2];
  bit         emit_ten[2];
  logic [1:0] e_coin  [2];
  bit         e_rej   [2];
  bit         e_ovf   [2];
  int         e_pend  [2];

  function automatic logic [7:0] exp_vec(input int m);
    return {e_coin[m], e_rej[m], e_ovf[m], 4'(e_pend[m])};
  endfunction

  // One clock edge of the behavioural model for instance m.
  task automatic model_step(input int m, input logic r5, input logic r10, input logic rs);
    bit ev0, ev1, rej, valid, sv;
    bit raw_now [2];
    int k;
    k = edge_n[m];
    edge_n[m] = k + 1;
    raw_now[0] = r5;
    raw_now[1] = r10;
    if (rs) begin
      rst_edge[m] = k;
      for (int c = 0; c < 2; c++) begin
        deb[m][c] = 1'b0; deb_old[m][c] = 1'b0; mis[m][c] = 0;
      end
      fq[m].delete();
      cool[m] = 0; emit_nx[m] = 1'b0;
      e_coin[m] = 2'b00; e_rej[m] = 1'b0; e_ovf[m] = 1'b0; e_pend[m] = 0;
    end else begin
      // a coin popped on the previous edge is shown for exactly this cycle
      e_coin[m] = emit_nx[m] ? (emit_ten[m] ? 2'b10 : 2'b01) : 2'b00;
      emit_nx[m] = 1'b0;
      ev0 = deb[m][0] && !deb_old[m][0];
      ev1 = deb[m][1] && !deb_old[m][1];
      rej = (ev0 && ev1) || (ev0 && deb[m][1]) || (ev1 && deb[m][0]);
      valid = (ev0 || ev1) && !rej;
      // after a pop the next pop is allowed GAP+2 edges later
      if (cool[m] > 0) begin
        cool[m] = cool[m] - 1;
      end else if (fq[m].size() > 0) begin
        emit_ten[m] = fq[m].pop_front();
        emit_nx[m] = 1'b1;
        cool[m] = P_G[m] + 1;
      end
      e_ovf[m] = 1'b0;
      if (valid) begin
        if (fq[m].size() >= P_DEP[m]) e_ovf[m] = 1'b1;
        else fq[m].push_back(ev1);
      end
      e_rej[m] = rej;
      e_pend[m] = fq[m].size();
      for (int c = 0; c < 2; c++) begin
        // synchronised value = raw sampled two edges ago (zero right after reset)
        sv = (k - rst_edge[m] >= 3) ? samp[m][c][(k - 2) % SN] : 1'b0;
        deb_old[m][c] = deb[m][c];
        if (sv != deb[m][c]) mis[m][c] = mis[m][c] + 1;
        else mis[m][c] = 0;
        if (mis[m][c] == P_D[m]) begin
          deb[m][c] = !deb[m][c];
          mis[m][c] = 0;
        end
        samp[m][c][k % SN] = raw_now[c];
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model and stop 1 time unit after the edge.
  task automatic cyc(input logic i_a5, input logic i_a10, input logic i_b5,
                     input logic i_b10, input logic i_rst);
    a5 = i_a5; a10 = i_a10; b5 = i_b5; b10 = i_b10; rst = i_rst;
    @(posedge clk);
    model_step(0, i_a5, i_a10, i_rst);
    model_step(1, i_b5, i_b10, i_rst);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (got_v[m] !== 8'h00) begin
          errors++;
          $display("FAIL reset dut%0d got=%h want=00", m, got_v[m]);
        end
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single_five();
    int pulses [2], first [2], maxp [2], rejs [2];
    for (int m = 0; m < 2; m++) begin
      pulses[m] = 0; first[m] = -1; maxp[m] = 0; rejs[m] = 0;
    end
    for (int i = 0; i < 40; i++) begin
      cyc(i < 10, 1'b0, i < 10, 1'b0, 1'b0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (got_v[m] !== exp_vec(m)) begin
          errors++;
          $display("FAIL single_five dut%0d cyc%0d got=%h want=%h", m, i, got_v[m], exp_vec(m));
        end
        if (got_v[m][7:6] == 2'b01) begin
          pulses[m]++;
          if (first[m] < 0) first[m] = i;
        end
        if (int'(got_v[m][3:0]) > maxp[m]) maxp[m] = int'(got_v[m][3:0]);
        if (got_v[m][5]) rejs[m]++;
      end
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (pulses[m] != 1 || first[m] != P_D[m] + 4 || maxp[m] != 1 || rejs[m] != 0) begin
        errors++;
        $display("FAIL single_five_summary dut%0d pulses=%0d first=%0d maxpend=%0d rejects=%0d want 1/%0d/1/0",
                 m, pulses[m], first[m], maxp[m], rejs[m], P_D[m] + 4);
      end
    end
  endtask

  task automatic test_bounce_ten();
    int pulses [2], others [2];
    logic v;
    for (int m = 0; m < 2; m++) begin pulses[m] = 0; others[m] = 0; end
    for (int i = 0; i < 44; i++) begin
      v = (i < 4) ? ((i % 2) == 0) : (i < 14);
      cyc(1'b0, v, 1'b0, v, 1'b0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (got_v[m] !== exp_vec(m)) begin
          errors++;
          $display("FAIL bounce_ten dut%0d cyc%0d got=%h want=%h", m, i, got_v[m], exp_vec(m));
        end
        if (got_v[m][7:6] == 2'b10) pulses[m]++;
        else if (got_v[m][7:6] != 2'b00 || got_v[m][5]) others[m]++;
      end
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (pulses[m] != 1 || others[m] != 0) begin
        errors++;
        $display("FAIL bounce_ten_summary dut%0d ten_pulses=%0d other=%0d want 1/0", m, pulses[m], others[m]);
      end
    end
  endtask

  task automatic test_simultaneous_reject();
    int pulses [2], rejs [2], maxp [2];
    for (int m = 0; m < 2; m++) begin pulses[m] = 0; rejs[m] = 0; maxp[m] = 0; end
    for (int i = 0; i < 40; i++) begin
      cyc(i < 10, i < 10, i < 10, i < 10, 1'b0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (got_v[m] !== exp_vec(m)) begin
          errors++;
          $display("FAIL simul_reject dut%0d cyc%0d got=%h want=%h", m, i, got_v[m], exp_vec(m));
        end
        if (got_v[m][7:6] != 2'b00) pulses[m]++;
        if (got_v[m][5]) rejs[m]++;
        if (int'(got_v[m][3:0]) > maxp[m]) maxp[m] = int'(got_v[m][3:0]);
      end
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (pulses[m] != 0 || rejs[m] != 1 || maxp[m] != 0) begin
        errors++;
        $display("FAIL simul_reject_summary dut%0d pulses=%0d rejects=%0d maxpend=%0d want 0/1/0",
                 m, pulses[m], rejs[m], maxp[m]);
      end
    end
  endtask

  // Ten-coins every 4 cycles into the shallow instance: arrival outpaces the
  // 5-cycle drain, so the queue fills and later coins overflow.
  task automatic test_overflow();
    int pulses, ovfs, maxp, rejs, last, idle_pulses;
    pulses = 0; ovfs = 0; maxp = 0; rejs = 0; last = -100; idle_pulses = 0;
    for (int i = 0; i < 124; i++) begin
      cyc(1'b0, 1'b0, 1'b0, (i < 64) && ((i % 4) < 2), 1'b0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (got_v[m] !== exp_vec(m)) begin
          errors++;
          $display("FAIL overflow dut%0d cyc%0d got=%h want=%h", m, i, got_v[m], exp_vec(m));
        end
      end
      if (coin_a != 2'b00) idle_pulses++;
      if (coin_b != 2'b00) begin
        pulses++;
        checks++;
        if (i - last < P_G[1] + 2) begin
          errors++;
          $display("FAIL overflow_spacing cyc%0d spacing=%0d want>=%0d", i, i - last, P_G[1] + 2);
        end
        last = i;
      end
      if (ovf_b) ovfs++;
      if (rej_b) rejs++;
      if (int'(pend_b) > maxp) maxp = int'(pend_b);
    end
    checks++;
    if (ovfs == 0 || pulses + ovfs != 16 || maxp != 2 || rejs != 0 || idle_pulses != 0) begin
      errors++;
      $display("FAIL overflow_summary pulses=%0d overflows=%0d maxpend=%0d rejects=%0d idle_dut_pulses=%0d want ovf>0, sum 16, 2, 0, 0",
               pulses, ovfs, maxp, rejs, idle_pulses);
    end
  endtask

  task automatic test_alternating();
    logic [1:0] seq [2][4];
    logic [1:0] want [3];
    logic [1:0] prev [2];
    int n [2], bad [2];
    logic v5, v10;
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01;
    for (int m = 0; m < 2; m++) begin n[m] = 0; bad[m] = 0; prev[m] = 2'b00; end
    for (int i = 0; i < 70; i++) begin
      v5  = (i < 8) || (i >= 36 && i < 44);
      v10 = (i >= 18 && i < 26);
      cyc(v5, v10, v5, v10, 1'b0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (got_v[m] !== exp_vec(m)) begin
          errors++;
          $display("FAIL alternating dut%0d cyc%0d got=%h want=%h", m, i, got_v[m], exp_vec(m));
        end
        if (got_v[m][7:6] == 2'b11 || (got_v[m][7:6] != 2'b00 && prev[m] != 2'b00)) bad[m]++;
        if (got_v[m][7:6] != 2'b00) begin
          if (n[m] < 4) seq[m][n[m]] = got_v[m][7:6];
          n[m]++;
        end
        prev[m] = got_v[m][7:6];
      end
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (n[m] != 3 || bad[m] != 0 || seq[m][0] !== want[0] || seq[m][1] !== want[1] || seq[m][2] !== want[2]) begin
        errors++;
        $display("FAIL alternating_order dut%0d count=%0d bad=%0d seq=%b,%b,%b want 3/0/01,10,01",
                 m, n[m], bad[m], seq[m][0], seq[m][1], seq[m][2]);
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    bit hit;
    int pulses;
    hit = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cyc(1'b0, 1'b0, 1'b0, (i % 4) < 2, 1'b0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (got_v[m] !== exp_vec(m)) begin
          errors++;
          $display("FAIL reset_mid_emit_fill dut%0d cyc%0d got=%h want=%h", m, i, got_v[m], exp_vec(m));
        end
      end
      // instance 1 is in EMIT with at least one more coin still queued
      if (emit_nx[1] && fq[1].size() > 0) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_emit_setup got=no_emit_with_queue want=emit_with_queue");
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (got_v[m] !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid_emit dut%0d got=%h want=00", m, got_v[m]);
      end
    end
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (got_v[m] !== exp_vec(m)) begin
          errors++;
          $display("FAIL reset_mid_emit_after dut%0d cyc%0d got=%h want=%h", m, i, got_v[m], exp_vec(m));
        end
        if (got_v[m] != 8'h00) pulses++;
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_emit_quiet activity=%0d want=0", pulses);
    end
  endtask

  task automatic test_random();
    int hold [4];
    logic val [4];
    logic r;
    int last [2];
    for (int j = 0; j < 4; j++) begin hold[j] = 0; val[j] = 1'b0; end
    last[0] = -100; last[1] = -100;
    for (int i = 0; i < 1500; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (hold[j] == 0) begin
          val[j] = ($urandom_range(0, 2) == 0);
          hold[j] = $urandom_range(1, 12);
        end
        hold[j]--;
      end
      r = ($urandom_range(0, 499) == 0);
      cyc(val[0], val[1], val[2], val[3], r);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (got_v[m] !== exp_vec(m)) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d got=%h want=%h", m, i, got_v[m], exp_vec(m));
        end
        if (r) last[m] = -100;
        if (got_v[m][7:6] != 2'b00) begin
          checks++;
          if (got_v[m][7:6] == 2'b11 || i - last[m] < P_G[m] + 2) begin
            errors++;
            $display("FAIL random_output_rules dut%0d cyc%0d coin=%b spacing=%0d want code!=11 spacing>=%0d",
                     m, i, got_v[m][7:6], i - last[m], P_G[m] + 2);
          end
          last[m] = i;
        end
        if (got_v[m][5] && got_v[m][4]) begin
          errors++;
          $display("FAIL random_pulse_excl dut%0d cyc%0d reject=1 overflow=1 want not both", m, i);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_five();
    test_bounce_ten();
    test_simultaneous_reject();
    test_overflow();
    test_alternating();
    test_reset_mid_emit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
